// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for one single-port dmem: the processor has priority, and VGA preempts after MAX_WAIT blocked cycles.
// Optional grant/preemption counters are enabled with macro DMEM_ARB_STATS_EN.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              p_req,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_data,
  input  logic              p_wren,
  output logic              p_stall,
  output logic [DATA_W-1:0] p_q,
  output logic              p_rvalid,
  input  logic              v_req,
  input  logic [ADDR_W-1:0] v_addr,
  input  logic [DATA_W-1:0] v_data,
  input  logic              v_wren,
  output logic              v_gnt,
  output logic [DATA_W-1:0] v_q,
  output logic              v_rvalid,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data,
  output logic              m_wren,
  input  logic [DATA_W-1:0] m_q
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_p_grants,
  output logic [15:0]       stat_v_grants,
  output logic [15:0]       stat_preempt
`endif
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, PROC, VGA} owner_t;

  owner_t     owner, owner_nxt;
  logic [3:0] wait_cnt, wait_nxt;
  logic       p_gnt;
  logic       preempt;

  // Grants are gated by resetn so that nothing reaches dmem while reset is held.
  assign preempt = v_req & (wait_cnt == MAX_W);
  assign p_gnt   = resetn & p_req & ~preempt;
  assign v_gnt   = resetn & v_req & ~p_gnt;
  assign p_stall = p_req & v_gnt;

  always_comb begin
    m_addr = '0;
    m_data = '0;
    m_wren = 1'b0;
    if (p_gnt) begin
      m_addr = p_addr;
      m_data = p_data;
      m_wren = p_wren;
    end else if (v_gnt) begin
      m_addr = v_addr;
      m_data = v_data;
      m_wren = v_wren;
    end
  end

  // A withdrawn or granted request restarts the wait count.
  always_comb begin
    wait_nxt = 4'd0;
    if (v_req && !v_gnt)
      wait_nxt = (wait_cnt >= MAX_W) ? MAX_W : wait_cnt + 4'd1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) wait_cnt <= 4'd0;
    else         wait_cnt <= wait_nxt;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) owner <= IDLE;
    else         owner <= owner_nxt;
  end

  // Owner tracks whose read data arrives on m_q in the following cycle.
  always_comb begin
    owner_nxt = IDLE;
    if (p_gnt && !p_wren)      owner_nxt = PROC;
    else if (v_gnt && !v_wren) owner_nxt = VGA;
  end

  always_comb begin
    p_rvalid = (owner == PROC);
    v_rvalid = (owner == VGA);
  end

  assign p_q = m_q;
  assign v_q = m_q;

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stat_p_grants <= 16'd0;
      stat_v_grants <= 16'd0;
      stat_preempt  <= 16'd0;
    end else begin
      if (p_gnt)   stat_p_grants <= stat_p_grants + 16'd1;
      if (v_gnt)   stat_v_grants <= stat_v_grants + 16'd1;
      if (p_stall) stat_preempt  <= stat_preempt + 16'd1;
    end
  end
`endif

endmodule
